gc_ctrl_apb: RTL and testbench

//  APB3 slave in the fabric, directly downstream of the gc_MSS APB master port.
//  The MSS writes a poll command. The block runs the GameCube controller serial

---
 rtl/gc_pkg.sv | 50 +++++
 rtl/gc_us_tick.sv | 52 +++++
 rtl/gc_ctrl_apb.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_gc_ctrl_apb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared definitions for the GameCube controller APB slave.
// Holds the register map, register bit positions, the poll command word,
// the controller FSM state type and a small phase-timing helper.
package gc_pkg;

    // Register byte offsets on the APB bus
    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_DATA_HI = 8'h08;
    localparam logic [7:0] ADDR_DATA_LO = 8'h0C;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_RUMBLE = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

    // Poll command; bit 0 carries the rumble request
    localparam logic [23:0] GC_CMD_POLL = 24'h400300;
    localparam int CMD_BITS  = 24;
    localparam int RESP_BITS = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TX_LOW    = 3'd1,
        S_TX_HIGH   = 3'd2,
        S_TX_STOP   = 3'd3,
        S_RX_WAIT   = 3'd4,
        S_RX_SAMPLE = 3'd5,
        S_RX_STOP   = 3'd6
    } gc_state_e;

    // True on the last cycle of a phase lasting dur microseconds,
    // given a counter that was reloaded on the first cycle of the phase.
    function automatic logic phase_end(input logic tick, input logic [15:0] us_cnt,
                                       input logic [15:0] dur);
        return tick && (us_cnt == (dur - 16'd1));
    endfunction

    // True for the four decoded register offsets
    function automatic logic addr_mapped(input logic [7:0] addr);
        return (addr == ADDR_CTRL) || (addr == ADDR_STATUS) ||
               (addr == ADDR_DATA_HI) || (addr == ADDR_DATA_LO);
    endfunction

endpackage

// File: rtl/gc_us_tick.sv
// Microsecond timebase for the controller FSM.
// A prescaler produces a one-cycle strobe every TICKS_PER_US clocks and a
// counter accumulates whole microseconds since the last reload. Reload zeroes
// both, so a phase started with reload lasts exactly N*TICKS_PER_US cycles
// when it ends on the strobe with o_us_cnt == N-1.
// Ports:
//   i_clk     clock
//   i_rst_n   async active-low reset
//   i_reload  restart prescaler and microsecond count
//   o_tick    one-cycle strobe at the end of each microsecond
//   o_us_cnt  whole microseconds elapsed since reload (saturating)
module gc_us_tick #(
    parameter int unsigned TICKS_PER_US = 40
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_reload,
    output logic        o_tick,
    output logic [15:0] o_us_cnt
);

    localparam logic [15:0] PRE_MAX = 16'(TICKS_PER_US - 1);

    logic [15:0] r_pre;
    logic [15:0] r_us;
    logic        w_wrap;

    assign w_wrap   = (r_pre == PRE_MAX);
    assign o_tick   = w_wrap;
    assign o_us_cnt = r_us;

    // Prescaler and elapsed-microsecond counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= 16'd0;
            r_us  <= 16'd0;
        end else if (i_reload) begin
            r_pre <= 16'd0;
            r_us  <= 16'd0;
        end else if (w_wrap) begin
            r_pre <= 16'd0;
            if (r_us != 16'hFFFF) begin
                r_us <= r_us + 16'd1;
            end else begin
                r_us <= r_us;
            end
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

endmodule

// File: rtl/gc_ctrl_apb.sv
// APB3 slave that polls a GameCube controller over one open-drain line.
// A START write sends the 24-bit poll command MSB first, then the 64-bit
// response is sampled into a shadow register and published to DATA_HI/LO.
// Missing or stalled responses end the transfer with STATUS.TIMEOUT.
// Ports:
//   PCLK, PRESERN         clock, async active-low reset
//   PSEL/PENABLE/PWRITE   APB control
//   PADDR[7:0], PWDATA    APB address / write data
//   PRDATA, PREADY        read data (valid in access phase), always ready
//   PSLVERR               error for unmapped offsets, access phase only
//   GC_DATA_IN            raw line level (asynchronous)
//   GC_DATA_OE            1 pulls the line low
//   GC_IRQ                STATUS.DONE & CTRL.IRQ_EN
module gc_ctrl_apb
    import gc_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 40_000_000,
    parameter int unsigned TIMEOUT_US  = 200,
    parameter int unsigned GAP_US      = 8
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        GC_DATA_IN,
    output logic        GC_DATA_OE,
    output logic        GC_IRQ
);

    localparam int unsigned TICKS_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam logic [15:0] TIMEOUT_LIM  = 16'(TIMEOUT_US);
    localparam logic [15:0] GAP_LIM      = 16'(GAP_US);
    localparam logic [6:0]  CMD_LAST     = 7'(CMD_BITS - 1);
    localparam logic [6:0]  RESP_LAST    = 7'(RESP_BITS - 1);

    gc_state_e r_state, w_state_nxt;

    logic        r_rumble, r_irq_en, r_done, r_timeout;
    logic [63:0] r_data, r_shadow;
    logic [23:0] r_cmd;
    logic [6:0]  r_bit_cnt;
    logic        r_sync1, r_sync2, r_sync3;
    logic        r_oe, r_irq, r_pslverr;
    logic [31:0] r_prdata;

    logic        w_tick;
    logic [15:0] w_us_cnt;
    logic        w_reload, w_start_ok, w_tx_shift, w_rx_shift;
    logic        w_bit_inc, w_bit_clr, w_set_done, w_set_to;
    logic        w_apb_wr, w_apb_setup, w_start_req, w_fall;
    logic        w_tx_bit;
    logic [15:0] w_lo_dur, w_hi_dur, w_rx_lim;
    logic        w_rumble_nxt, w_irq_en_nxt, w_done_nxt, w_to_nxt, w_busy_nxt;
    logic [63:0] w_data_nxt;
    logic [31:0] w_rd_data;
    logic        w_oe_nxt;
    logic        w_unused;

    assign w_unused = ^PWDATA[31:3];

    gc_us_tick #(.TICKS_PER_US(TICKS_PER_US)) u_tick (
        .i_clk    (PCLK),
        .i_rst_n  (PRESERN),
        .i_reload (w_reload),
        .o_tick   (w_tick),
        .o_us_cnt (w_us_cnt)
    );

    assign w_apb_wr    = PSEL & PENABLE & PWRITE;
    assign w_apb_setup = PSEL & ~PENABLE;
    assign w_start_req = w_apb_wr && (PADDR == ADDR_CTRL) && PWDATA[CTRL_START];
    assign w_fall      = r_sync3 & ~r_sync2;

    assign w_tx_bit = r_cmd[CMD_BITS-1];
    assign w_lo_dur = w_tx_bit ? 16'd1 : 16'd3;
    assign w_hi_dur = w_tx_bit ? 16'd3 : 16'd1;
    // The first response edge gets the long window; later edges the bit gap
    assign w_rx_lim = (r_bit_cnt == 7'd0) ? TIMEOUT_LIM : GAP_LIM;

    // FSM state register
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and datapath control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        w_start_ok  = 1'b0;
        w_tx_shift  = 1'b0;
        w_rx_shift  = 1'b0;
        w_bit_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        w_set_done  = 1'b0;
        w_set_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_req) begin
                    w_state_nxt = S_TX_LOW;
                    w_reload    = 1'b1;
                    w_start_ok  = 1'b1;
                    w_bit_clr   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TX_LOW: begin
                if (phase_end(w_tick, w_us_cnt, w_lo_dur)) begin
                    w_state_nxt = S_TX_HIGH;
                    w_reload    = 1'b1;
                end else begin
                    w_state_nxt = S_TX_LOW;
                end
            end
            S_TX_HIGH: begin
                if (phase_end(w_tick, w_us_cnt, w_hi_dur)) begin
                    w_reload   = 1'b1;
                    w_tx_shift = 1'b1;
                    if (r_bit_cnt == CMD_LAST) begin
                        w_state_nxt = S_TX_STOP;
                    end else begin
                        w_state_nxt = S_TX_LOW;
                        w_bit_inc   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_TX_HIGH;
                end
            end
            S_TX_STOP: begin
                // Reload here so the first-edge timeout counts from release
                if (phase_end(w_tick, w_us_cnt, 16'd1)) begin
                    w_state_nxt = S_RX_WAIT;
                    w_reload    = 1'b1;
                    w_bit_clr   = 1'b1;
                end else begin
                    w_state_nxt = S_TX_STOP;
                end
            end
            S_RX_WAIT: begin
                // Reload only on edges, so the count spans low-to-low spacing
                if (w_fall) begin
                    w_state_nxt = S_RX_SAMPLE;
                    w_reload    = 1'b1;
                end else if (phase_end(w_tick, w_us_cnt, w_rx_lim)) begin
                    w_state_nxt = S_IDLE;
                    w_set_to    = 1'b1;
                end else begin
                    w_state_nxt = S_RX_WAIT;
                end
            end
            S_RX_SAMPLE: begin
                if (phase_end(w_tick, w_us_cnt, 16'd2)) begin
                    w_rx_shift = 1'b1;
                    if (r_bit_cnt == RESP_LAST) begin
                        w_state_nxt = S_RX_STOP;
                    end else begin
                        w_state_nxt = S_RX_WAIT;
                        w_bit_inc   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_RX_SAMPLE;
                end
            end
            S_RX_STOP: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    w_set_done  = 1'b1;
                end else if (phase_end(w_tick, w_us_cnt, GAP_LIM)) begin
                    w_state_nxt = S_IDLE;
                    w_set_to    = 1'b1;
                end else begin
                    w_state_nxt = S_RX_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of software-visible registers; set beats w1c
    always_comb begin
        w_rumble_nxt = r_rumble;
        w_irq_en_nxt = r_irq_en;
        w_done_nxt   = r_done;
        w_to_nxt     = r_timeout;
        if (w_apb_wr && (PADDR == ADDR_CTRL)) begin
            w_rumble_nxt = PWDATA[CTRL_RUMBLE];
            w_irq_en_nxt = PWDATA[CTRL_IRQ_EN];
        end else begin
            w_rumble_nxt = r_rumble;
            w_irq_en_nxt = r_irq_en;
        end
        if (w_apb_wr && (PADDR == ADDR_STATUS)) begin
            w_done_nxt = r_done & ~PWDATA[STAT_DONE];
            w_to_nxt   = r_timeout & ~PWDATA[STAT_TIMEOUT];
        end else begin
            w_done_nxt = r_done;
            w_to_nxt   = r_timeout;
        end
        if (w_start_ok) begin
            w_done_nxt = 1'b0;
            w_to_nxt   = 1'b0;
        end else begin
            w_done_nxt = w_done_nxt;
            w_to_nxt   = w_to_nxt;
        end
        if (w_set_done) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = w_done_nxt;
        end
        if (w_set_to) begin
            w_to_nxt = 1'b1;
        end else begin
            w_to_nxt = w_to_nxt;
        end
        w_data_nxt = w_set_done ? r_shadow : r_data;
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Read mux over next-cycle register values, so data landing at the
    // setup-phase edge is what the access phase returns
    always_comb begin
        w_rd_data = 32'd0;
        case (PADDR)
            ADDR_CTRL:    w_rd_data = {29'd0, w_irq_en_nxt, w_rumble_nxt, 1'b0};
            ADDR_STATUS:  w_rd_data = {29'd0, w_to_nxt, w_done_nxt, w_busy_nxt};
            ADDR_DATA_HI: w_rd_data = w_data_nxt[63:32];
            ADDR_DATA_LO: w_rd_data = w_data_nxt[31:0];
            default:      w_rd_data = 32'd0;
        endcase
    end

    // Line is only pulled during the low phases of command and stop bits
    assign w_oe_nxt = (w_state_nxt == S_TX_LOW) || (w_state_nxt == S_TX_STOP);

    // Register file, shift registers, synchroniser and registered outputs
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_rumble  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_data    <= 64'd0;
            r_shadow  <= 64'd0;
            r_cmd     <= 24'd0;
            r_bit_cnt <= 7'd0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_oe      <= 1'b0;
            r_irq     <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= 32'd0;
        end else begin
            r_rumble  <= w_rumble_nxt;
            r_irq_en  <= w_irq_en_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_to_nxt;
            r_data    <= w_data_nxt;
            r_sync1   <= GC_DATA_IN;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_oe      <= w_oe_nxt;
            r_irq     <= w_done_nxt & w_irq_en_nxt;
            r_pslverr <= w_apb_setup & ~addr_mapped(PADDR);
            r_prdata  <= (w_apb_setup && !PWRITE) ? w_rd_data : 32'd0;
            if (w_start_ok) begin
                r_cmd <= GC_CMD_POLL | {23'd0, PWDATA[CTRL_RUMBLE]};
            end else if (w_tx_shift) begin
                r_cmd <= {r_cmd[CMD_BITS-2:0], 1'b0};
            end else begin
                r_cmd <= r_cmd;
            end
            if (w_rx_shift) begin
                r_shadow <= {r_shadow[RESP_BITS-2:0], r_sync2};
            end else begin
                r_shadow <= r_shadow;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= 7'd0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 7'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    assign PRDATA     = r_prdata;
    assign PREADY     = 1'b1;
    assign PSLVERR    = r_pslverr;
    assign GC_DATA_OE = r_oe;
    assign GC_IRQ     = r_irq;

endmodule

// File: tb/tb_gc_ctrl_apb.sv
// Self-checking bench for gc_ctrl_apb: drives APB transfers, decodes the
// command waveform from GC_DATA_OE, plays a controller that answers with
// random 64-bit responses, and compares registers to a register-level model.
module tb_gc_ctrl_apb;

    localparam int U = 8;   // clocks per microsecond at 8 MHz

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h00;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, GC_DATA_OE, GC_IRQ;
    logic        ctrl_drive = 1'b0;
    logic        GC_DATA_IN;

    assign GC_DATA_IN = ~(GC_DATA_OE | ctrl_drive);

    always #5 PCLK = ~PCLK;

    gc_ctrl_apb #(.CLK_FREQ_HZ(8_000_000), .TIMEOUT_US(200), .GAP_US(8)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .GC_DATA_IN(GC_DATA_IN),
        .GC_DATA_OE(GC_DATA_OE), .GC_IRQ(GC_IRQ)
    );

    int n_vec = 0;
    int n_err = 0;

    // Waveform monitor: start cycle and width of every low pulse on OE
    int   cyc = 0;
    logic oe_prev = 1'b0;
    int   lo_start_q[$];
    int   lo_w_q[$];
    logic rx_window = 1'b0;
    logic oe_in_rx = 1'b0;

    always @(negedge PCLK) begin
        cyc = cyc + 1;
        if (GC_DATA_OE && !oe_prev) lo_start_q.push_back(cyc);
        if (!GC_DATA_OE && oe_prev && lo_start_q.size() > 0)
            lo_w_q.push_back(cyc - lo_start_q[$]);
        if (rx_window && GC_DATA_OE) oe_in_rx = 1'b1;
        oe_prev = GC_DATA_OE;
    end

    // Register-level reference model
    logic        m_rumble = 1'b0, m_irq = 1'b0, m_done = 1'b0, m_to = 1'b0;
    logic [63:0] m_data = 64'h0;

    function automatic logic [31:0] exp_reg(input logic [7:0] a);
        case (a)
            8'h00:   return {29'd0, m_irq, m_rumble, 1'b0};
            8'h04:   return {29'd0, m_to, m_done, 1'b0};
            8'h08:   return m_data[63:32];
            8'h0C:   return m_data[31:0];
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick(1);
        PENABLE = 1'b1;
        err = PSLVERR;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        tick(1);
        PENABLE = 1'b1;
        d = PRDATA;
        err = PSLVERR;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        logic [31:0] rd;
        logic        err;
        logic [7:0]  a;
        for (int i = 0; i < 4; i++) begin
            a = 8'(i * 4);
            apb_read(a, rd, err);
            chk({tag, "_reg"}, {24'h0, a, rd}, {24'h0, a, exp_reg(a)});
            chk({tag, "_pslverr"}, err, 1'b0);
        end
    endtask

    // mode 0 normal, 1 silent controller, 2 START retried mid-response,
    // 3 reset asserted at response bit 30
    task automatic do_transfer(input logic rumble, input logic irq_en,
                               input logic [63:0] resp, input int mode);
        logic [23:0] cmd;
        logic [31:0] rd;
        logic        err, b, found;
        int          rel, n, elapsed;
        lo_start_q.delete();
        lo_w_q.delete();
        apb_write(8'h00, {29'd0, irq_en, rumble, 1'b1}, err);
        m_rumble = rumble; m_irq = irq_en; m_done = 1'b0; m_to = 1'b0;
        cmd = 24'h400300 | {23'd0, rumble};
        apb_read(8'h04, rd, err);
        chk("busy_during_tx", rd, 32'h1);
        n = 0;
        while (lo_w_q.size() < 25 && n < 4000) begin tick(1); n++; end
        chk("tx_pulse_count", lo_w_q.size(), 25);
        if (lo_w_q.size() >= 25) begin
            for (int i = 0; i < 24; i++) begin
                chk($sformatf("tx_low_width_b%0d", 23 - i), lo_w_q[i], cmd[23-i] ? U : 3 * U);
                chk($sformatf("tx_period_b%0d", 23 - i), lo_start_q[i+1] - lo_start_q[i], 4 * U);
            end
            chk("tx_stop_width", lo_w_q[24], U);
            rel = lo_start_q[24] + lo_w_q[24];
        end else begin
            rel = cyc;
        end
        rx_window = 1'b1;
        oe_in_rx = 1'b0;
        if (mode == 1) begin
            found = 1'b0;
            n = 0;
            while (!found && n < 2000) begin
                apb_read(8'h04, rd, err);
                found = rd[2];
                n++;
            end
            elapsed = cyc - rel;
            chk("timeout_seen", found, 1'b1);
            chk("timeout_latency_in_window",
                (elapsed >= 199 * U && elapsed <= 201 * U + 4), 1'b1);
            m_to = 1'b1;
            chk_regs("timeout");
            chk("timeout_irq", GC_IRQ, 1'b0);
        end else begin
            tick($urandom_range(2 * U, 20 * U));
            for (int i = 0; i < 64; i++) begin
                b = resp[63-i];
                if (mode == 3 && i == 30) begin
                    ctrl_drive = 1'b0;
                    PRESERN = 1'b0;
                    #1;
                    chk("rst_mid_oe", GC_DATA_OE, 1'b0);
                    chk("rst_mid_irq", GC_IRQ, 1'b0);
                    chk("rst_mid_prdata", PRDATA, 32'h0);
                    m_rumble = 1'b0; m_irq = 1'b0; m_done = 1'b0; m_to = 1'b0;
                    m_data = 64'h0;
                    tick(2);
                    PRESERN = 1'b1;
                    tick(2);
                    chk_regs("after_mid_reset");
                    rx_window = 1'b0;
                    return;
                end
                ctrl_drive = 1'b1;
                tick(b ? U : 3 * U);
                ctrl_drive = 1'b0;
                if (mode == 2 && i == 20) begin
                    apb_write(8'h00, {29'd0, irq_en, rumble, 1'b1}, err);
                    tick((b ? 3 * U : U) - 2);
                end else begin
                    tick(b ? 3 * U : U);
                end
            end
            ctrl_drive = 1'b1;
            tick(U);
            ctrl_drive = 1'b0;
            tick(4);
            m_done = 1'b1;
            m_data = resp;
            chk_regs("resp");
            chk("resp_irq", GC_IRQ, irq_en);
            chk("no_extra_tx", lo_w_q.size(), 25);
        end
        chk("oe_quiet_in_rx", oe_in_rx, 1'b0);
        rx_window = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        // 1. reset state
        tick(3);
        chk("rst_oe", GC_DATA_OE, 1'b0);
        chk("rst_irq", GC_IRQ, 1'b0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        PRESERN = 1'b1;
        tick(2);
        chk_regs("reset");
        chk("pready", PREADY, 1'b1);

        // 2. nominal poll with fixed response
        do_transfer(1'b0, 1'b1, 64'h0080_8080_8080_0000, 0);

        // 3. silent controller, then clear TIMEOUT
        do_transfer(1'b0, 1'b1, 64'h0, 1);
        apb_write(8'h04, 32'h4, err);
        m_to = 1'b0;
        chk_regs("to_w1c");

        // 4. START while busy is ignored; DONE w1c drops the interrupt
        do_transfer(1'b0, 1'b1, {$urandom, $urandom}, 2);
        apb_write(8'h04, 32'h2, err);
        m_done = 1'b0;
        chk_regs("done_w1c");
        chk("done_w1c_irq", GC_IRQ, 1'b0);

        // 5. unmapped read and write to read-only data
        apb_read(8'h10, rd, err);
        chk("unmapped_pslverr", err, 1'b1);
        chk("unmapped_prdata", rd, 32'h0);
        apb_write(8'h08, 32'hFFFF_FFFF, err);
        chk("ro_write_pslverr", err, 1'b0);
        chk_regs("ro_write");

        // 6. reset mid-response, then rumble poll
        do_transfer(1'b0, 1'b0, {$urandom, $urandom}, 3);
        do_transfer(1'b1, 1'b1, {$urandom, $urandom}, 0);

        // random polls
        for (int k = 0; k < 2; k++) begin
            do_transfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        {$urandom, $urandom}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
